busca_instrucao: RTL and testbench

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao_pkg.sv | 30 +++
 rtl/busca_instrucao_contador_pc.sv | 28 ++
 rtl/busca_instrucao.sv | 119 +++++++++++
 tb/tb_busca_instrucao.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/busca_instrucao_pkg.sv
// Shared processor definitions: field widths, the halt opcode, the fetch-stage
// state encoding and the control-unit state constants.
package busca_instrucao_pkg;

  localparam int P_ADDR_W = 5;
  localparam int P_INST_W = 10;
  localparam int P_OPC_W  = 5;

  localparam logic [P_OPC_W-1:0] P_HALT_OPCODE = 5'b11111;

  typedef enum logic [2:0] {
    FS_IDLE   = 3'd0,
    FS_ISSUE  = 3'd1,
    FS_LATCH  = 3'd2,
    FS_VALID  = 3'd3,
    FS_HALTED = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    CU_WAIT    = 2'd0,
    CU_DECODE  = 2'd1,
    CU_EXECUTE = 2'd2
  } cu_state_t;

  // The fetch stage is busy whenever it is neither parked nor stopped.
  function automatic logic fetch_busy(input fetch_state_t s);
    return !(s == FS_IDLE || s == FS_HALTED);
  endfunction

endpackage

// File: rtl/busca_instrucao_contador_pc.sv
// Program counter: synchronous clear, parallel load, increment wrapping
// modulo 2^ADDR_W, otherwise hold.
module contador_pc #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: drives a synchronous ROM from the PC, latches the
// returned word and presents it to the control unit over valid/ready.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int                ADDR_W      = P_ADDR_W,
  parameter int                INST_W      = P_INST_W,
  parameter int                OPC_W       = P_OPC_W,
  parameter logic [OPC_W-1:0]  HALT_OPCODE = P_HALT_OPCODE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [INST_W-1:0]       rom_q,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [OPC_W-1:0]        inst_opcode,
  output logic [INST_W-OPC_W-1:0] inst_operand,
  output logic [ADDR_W-1:0]       inst_pc,
  input  logic                    jump_en,
  input  logic [ADDR_W-1:0]       jump_target,
  output logic                    busy,
  output logic                    halted
);

  // Handshake: an instruction is transferred on a rising edge where
  // inst_valid and inst_ready are both high; the presented fields hold
  // steady while inst_valid is high and inst_ready is low.

  fetch_state_t              r_state;
  fetch_state_t              w_next_state;
  logic [OPC_W-1:0]          r_opcode;
  logic [INST_W-OPC_W-1:0]   r_operand;
  logic [ADDR_W-1:0]         r_inst_pc;
  logic [ADDR_W-1:0]         w_pc;
  logic                      w_pc_load;
  logic [ADDR_W-1:0]         w_pc_load_val;
  logic                      w_pc_inc;
  logic                      w_handshake;
  logic                      w_is_halt;

  contador_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_pc_load),
    .i_load_val (w_pc_load_val),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  assign w_handshake = (r_state == FS_VALID) && inst_ready;
  assign w_is_halt   = (r_opcode == HALT_OPCODE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_pc_load     = 1'b0;
    w_pc_load_val = '0;
    w_pc_inc      = 1'b0;
    case (r_state)
      FS_IDLE: begin
        if (start) begin
          w_next_state = FS_ISSUE;
          w_pc_load    = 1'b1;
        end
      end
      FS_ISSUE: w_next_state = FS_LATCH;
      FS_LATCH: w_next_state = FS_VALID;
      FS_VALID: begin
        if (w_handshake) begin
          // A halt freezes the PC where it is; a jump request with it is dropped.
          if (w_is_halt) begin
            w_next_state = FS_HALTED;
          end else begin
            w_next_state = FS_ISSUE;
            if (jump_en) begin
              w_pc_load     = 1'b1;
              w_pc_load_val = jump_target;
            end else begin
              w_pc_inc = 1'b1;
            end
          end
        end
      end
      FS_HALTED: w_next_state = FS_HALTED;
      default:   w_next_state = FS_IDLE;
    endcase
  end

  // rom_q carries the word addressed during ISSUE by the time we reach LATCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_opcode  <= '0;
      r_operand <= '0;
      r_inst_pc <= '0;
    end else if (r_state == FS_LATCH) begin
      r_opcode  <= rom_q[INST_W-1 -: OPC_W];
      r_operand <= rom_q[INST_W-OPC_W-1:0];
      r_inst_pc <= w_pc;
    end
  end

  assign rom_address  = w_pc;
  assign inst_valid   = (r_state == FS_VALID);
  assign inst_opcode  = r_opcode;
  assign inst_operand = r_operand;
  assign inst_pc      = r_inst_pc;
  assign busy         = fetch_busy(r_state);
  assign halted       = (r_state == FS_HALTED);

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: a behavioural ROM and a transaction-level model of
// the fetch sequence (PC rules plus a queue of expected instructions).
module tb_busca_instrucao;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] rom_address;
  logic [9:0] rom_q;
  logic       inst_valid;
  logic       inst_ready;
  logic [4:0] inst_opcode;
  logic [4:0] inst_operand;
  logic [4:0] inst_pc;
  logic       jump_en;
  logic [4:0] jump_target;
  logic       busy;
  logic       halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  rom [32];
  logic [14:0] exp_q[$];  // {pc, instruction word}
  int          m_pc;
  logic        m_halted;

  busca_instrucao dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .rom_address  (rom_address),
    .rom_q        (rom_q),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_opcode  (inst_opcode),
    .inst_operand (inst_operand),
    .inst_pc      (inst_pc),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .busy         (busy),
    .halted       (halted)
  );

  // clock / synchronous ROM
  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= rom[rom_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic fill_rom_nonhalt;
    logic [9:0] w;
    for (int i = 0; i < 32; i++) begin
      w = 10'($urandom);
      if (w[9:5] == 5'h1f) w[9:5] = 5'h00;
      rom[i] = w;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    m_pc = 0;
    m_halted = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},   inst_valid,   0);
    check({tag, "_opcode"},  inst_opcode,  0);
    check({tag, "_operand"}, inst_operand, 0);
    check({tag, "_pc"},      inst_pc,      0);
    check({tag, "_busy"},    busy,         0);
    check({tag, "_halted"},  halted,       0);
    check({tag, "_romaddr"}, rom_address,  0);
  endtask

  task automatic do_start;
    start = 1'b1;
    step();
    start = 1'b0;
    m_pc = 0;
    m_halted = 1'b0;
    exp_q.delete();
    exp_q.push_back({5'd0, rom[0]});
  endtask

  // Called right after the start or handshake edge: the next instruction must
  // show up exactly two edges later and match the head of the scoreboard.
  task automatic wait_present;
    int n;
    logic [14:0] e;
    n = 0;
    while (!inst_valid && n < 10) begin
      step();
      n++;
    end
    check("latency", n, 2);
    check("valid", inst_valid, 1);
    check("busy", busy, 1);
    check("sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("pc", inst_pc, e[14:10]);
      check("opcode", inst_opcode, e[9:5]);
      check("operand", inst_operand, e[4:0]);
    end
  endtask

  task automatic check_hold(input string tag);
    logic [14:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : 15'h0;
    check({tag, "_valid"},   inst_valid,   1);
    check({tag, "_pc"},      inst_pc,      e[14:10]);
    check({tag, "_opcode"},  inst_opcode,  e[9:5]);
    check({tag, "_operand"}, inst_operand, e[4:0]);
    check({tag, "_romaddr"}, rom_address,  m_pc);
  endtask

  task automatic accept(input logic jmp, input logic [4:0] tgt);
    logic [14:0] e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    inst_ready  = 1'b1;
    jump_en     = jmp;
    jump_target = tgt;
    step();
    inst_ready  = 1'b0;
    jump_en     = 1'b0;
    check("valid_drop", inst_valid, 0);
    if (e[9:5] == 5'h1f) begin
      m_halted = 1'b1;
    end else begin
      m_pc = jmp ? int'(tgt) : (m_pc + 1) % 32;
      exp_q.push_back({5'(m_pc), rom[m_pc]});
    end
  endtask

  initial begin
    int exp_seq [4];
    reset = 1'b1; start = 1'b0; inst_ready = 1'b0; jump_en = 1'b0; jump_target = '0;
    fill_rom_nonhalt();
    step();
    do_reset();
    check_reset_state("reset");

    // two-word program ending in halt
    rom[0] = 10'h023;
    rom[1] = 10'h3E0;
    do_start();
    wait_present();
    accept(1'b0, 5'd0);
    wait_present();
    accept(1'b1, 5'd9);
    check("halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_pc_hold", rom_address, m_pc);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("halt_start_halted", halted, 1);
    check("halt_start_valid", inst_valid, 0);
    check("halt_start_romaddr", rom_address, m_pc);

    // stall in VALID with stray start and jump_en, then sequential fetch
    fill_rom_nonhalt();
    do_reset();
    check_reset_state("reset2");
    do_start();
    wait_present();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        jump_en = 1'b1;
        jump_target = 5'($urandom);
      end
      if (k == 2) start = 1'b1;
      step();
      jump_en = 1'b0;
      start = 1'b0;
      check_hold("stall");
    end
    accept(1'b0, 5'd0);
    wait_present();
    check("seq_pc1", inst_pc, 1);
    for (int k = 0; k < 3; k++) begin
      accept(1'b0, 5'd0);
      wait_present();
    end
    check("at_pc4", inst_pc, 4);
    accept(1'b1, 5'd20);
    wait_present();
    check("jump_pc20", inst_pc, 20);

    // wrap 30, 31, 0, 1
    exp_seq = '{30, 31, 0, 1};
    accept(1'b1, 5'd30);
    for (int k = 0; k < 4; k++) begin
      wait_present();
      check("wrap_seq", inst_pc, exp_seq[k]);
      accept(1'b0, 5'd0);
    end
    wait_present();

    // randomized ready stalls and jumps
    for (int it = 0; it < 60; it++) begin
      int stall;
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        jump_en = 1'($urandom_range(0, 1));
        jump_target = 5'($urandom);
        step();
        jump_en = 1'b0;
        check_hold("rnd_stall");
      end
      accept($urandom_range(0, 3) == 0, 5'($urandom));
      wait_present();
    end

    // reset while the ROM word is being latched
    do_reset();
    check_reset_state("reset3");
    do_start();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    m_pc = 0;
    check_reset_state("latch_reset");
    step();
    step();
    step();
    check("no_stale_valid", inst_valid, 0);
    check("no_stale_busy", busy, 0);
    do_start();
    wait_present();
    check("restart_pc0", inst_pc, 0);
    accept(1'b0, 5'd0);
    wait_present();
    check("restart_pc1", inst_pc, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
